// File: rtl/collision_pkg.sv
// collision_pkg
//   Shared types and helpers for the collision resolver block:
//   - score_t    : packed BCD score, digit 0 in the least significant nibble
//   - state_t    : score FSM states (IDLE, ADD, DONE)
//   - bcd_add()  : one saturating BCD add of a two-digit BCD constant
//   - LIVES_W    : width of the lives counter
package collision_pkg;

  localparam int SCORE_DIGITS_PKG = 4;
  localparam int LIVES_W          = 3;

  typedef logic [SCORE_DIGITS_PKG-1:0][3:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ripple BCD add: each digit is summed in binary, and any digit result
  // above 9 gets +6 so the low nibble wraps into 0..9 and a carry ripples on.
  // A carry out of the top digit pins the score at all nines.
  function automatic score_t bcd_add(input score_t s, input logic [7:0] pts);
    score_t     r;
    logic       carry;
    logic [4:0] sum;
    logic [3:0] addend;
    r     = '0;
    carry = 1'b0;
    for (int i = 0; i < SCORE_DIGITS_PKG; i++) begin
      if (i == 0)      addend = pts[3:0];
      else if (i == 1) addend = pts[7:4];
      else             addend = 4'd0;
      sum = {1'b0, s[i]} + {1'b0, addend} + {4'd0, carry};
      if (sum > 5'd9) begin
        sum   = sum + 5'd6;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      r[i] = sum[3:0];
    end
    if (carry) r = {SCORE_DIGITS_PKG{4'd9}};
    return r;
  endfunction

endpackage

// File: rtl/bcd_accumulator.sv
// bcd_accumulator
//   Holds the BCD score and performs one saturating add of POINTS_BCD on
//   every cycle that add_en is high.
//   Ports:
//     clk     in   pixel clock
//     resetN  in   asynchronous active-low reset (score -> 0)
//     add_en  in   add POINTS_BCD this cycle
//     score   out  current packed BCD score
module bcd_accumulator
  import collision_pkg::*;
#(
  parameter logic [7:0] POINTS_BCD = 8'h20
) (
  input  logic   clk,
  input  logic   resetN,
  input  logic   add_en,
  output score_t score
);

  score_t score_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q <= '0;
    end else if (add_en) begin
      score_q <= bcd_add(score_q, POINTS_BCD);
    end
  end

  assign score = score_q;

endmodule

// File: rtl/collision_resolver.sv
// collision_resolver
//   Detects pixel overlaps between torpedoes, asteroids and the ship during
//   the active frame, accumulates them in sticky flags and, at each vsync,
//   emits one-cycle hit pulses. Also tracks score (BCD), lives and game over.
//   Ports:
//     clk, resetN         pixel clock, asynchronous active-low reset
//     vsync               one-cycle frame pulse (in blanking)
//     torpedo_draw        per-torpedo Draw (already gated by t_fire)
//     t_fire              torpedo in-flight flags, sampled at vsync
//     asteroid_draw       per-asteroid Draw
//     ship_draw           ship sprite Draw
//     torpedo_collision   one-cycle hit pulse per torpedo
//     asteroid_hit        one-cycle destroy pulse per asteroid
//     ship_hit            one-cycle ship destroyed pulse
//     score               packed BCD score, digit 0 in LSBs
//     lives               remaining lives
//     game_over           sticky, set when lives reaches 0
//     score_busy          high while the score FSM sweeps the hit vector
module collision_resolver
  import collision_pkg::*;
#(
  parameter int TORPEDOS        = 2,
  parameter int ASTEROIDS       = 8,
  parameter int SCORE_DIGITS    = SCORE_DIGITS_PKG, // must match score_t
  parameter int ASTEROID_POINTS = 20,
  parameter int LIVES_INIT      = 3
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      vsync,
  input  logic [TORPEDOS-1:0]       torpedo_draw,
  input  logic [TORPEDOS-1:0]       t_fire,
  input  logic [ASTEROIDS-1:0]      asteroid_draw,
  input  logic                      ship_draw,
  output logic [TORPEDOS-1:0]       torpedo_collision,
  output logic [ASTEROIDS-1:0]      asteroid_hit,
  output logic                      ship_hit,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [LIVES_W-1:0]        lives,
  output logic                      game_over,
  output logic                      score_busy
);

  localparam int                IDX_W      = (ASTEROIDS > 1) ? $clog2(ASTEROIDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(ASTEROIDS - 1);
  localparam logic [7:0]        POINTS_BCD = {4'(ASTEROID_POINTS / 10), 4'(ASTEROID_POINTS % 10)};

  // Stage 1: registered draw inputs
  logic [TORPEDOS-1:0]  tdraw_q;
  logic [ASTEROIDS-1:0] adraw_q;
  logic                 sdraw_q;

  // Stage 2: registered overlap terms
  logic [TORPEDOS-1:0]  th_q;
  logic [ASTEROIDS-1:0] ah_q;
  logic                 sh_q;

  // Per-frame sticky accumulators
  logic [TORPEDOS-1:0]  t_st_q;
  logic [ASTEROIDS-1:0] a_st_q;
  logic                 s_st_q;

  // Pulse output registers
  logic [TORPEDOS-1:0]  tcoll_q;
  logic [ASTEROIDS-1:0] ahit_q;
  logic                 shit_q;

  logic [LIVES_W-1:0]   lives_q;
  logic                 game_over_q;

  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ASTEROIDS-1:0] vec_q;
  logic                 add_en;
  score_t               score_w;

  // Overlap pipeline, sticky accumulation and vsync snapshot
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tdraw_q <= '0;
      adraw_q <= '0;
      sdraw_q <= 1'b0;
      th_q    <= '0;
      ah_q    <= '0;
      sh_q    <= 1'b0;
      t_st_q  <= '0;
      a_st_q  <= '0;
      s_st_q  <= 1'b0;
      tcoll_q <= '0;
      ahit_q  <= '0;
      shit_q  <= 1'b0;
    end else begin
      tdraw_q <= torpedo_draw;
      adraw_q <= asteroid_draw;
      sdraw_q <= ship_draw;

      th_q <= tdraw_q & {TORPEDOS{|adraw_q}};
      ah_q <= adraw_q & {ASTEROIDS{(|tdraw_q) | sdraw_q}};
      sh_q <= sdraw_q & (|adraw_q);

      if (vsync) begin
        // Snapshot the frame, and seed the next frame with the term that
        // is in flight this cycle so no overlap falls between frames.
        tcoll_q <= t_st_q & t_fire;
        ahit_q  <= a_st_q;
        shit_q  <= s_st_q & ~game_over_q;
        t_st_q  <= th_q;
        a_st_q  <= ah_q;
        s_st_q  <= sh_q;
      end else begin
        tcoll_q <= '0;
        ahit_q  <= '0;
        shit_q  <= 1'b0;
        t_st_q  <= t_st_q | th_q;
        a_st_q  <= a_st_q | ah_q;
        s_st_q  <= s_st_q | sh_q;
      end
    end
  end

  // Lives and game over; ship_hit is already suppressed once game over
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lives_q     <= LIVES_W'(LIVES_INIT);
      game_over_q <= 1'b0;
    end else if (shit_q && (lives_q != '0)) begin
      lives_q <= lives_q - 1'b1;
      if (lives_q == LIVES_W'(1)) game_over_q <= 1'b1;
    end
  end

  // Score FSM: sweep the latched hit vector one asteroid per cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((ahit_q != '0) && !game_over_q) begin
            vec_q   <= ahit_q;
            idx_q   <= '0;
            state_q <= ADD;
          end
        end
        ADD: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // game_over can rise mid-sweep (ship and asteroid hit in the same frame);
  // gating here keeps the score frozen from that edge on.
  assign add_en = (state_q == ADD) && vec_q[idx_q] && !game_over_q;

  bcd_accumulator #(
    .POINTS_BCD(POINTS_BCD)
  ) u_acc (
    .clk    (clk),
    .resetN (resetN),
    .add_en (add_en),
    .score  (score_w)
  );

  assign torpedo_collision = tcoll_q;
  assign asteroid_hit      = ahit_q;
  assign ship_hit          = shit_q;
  assign score             = score_w;
  assign lives             = lives_q;
  assign game_over         = game_over_q;
  assign score_busy        = (state_q == ADD) || (state_q == DONE);

endmodule
